// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: master requests in, granted/decoded bus out.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_DEVICES = 8,
    parameter int A_WIDTH     = 32
);
    logic [NUM_MASTERS-1:0]         req;
    logic [NUM_MASTERS*A_WIDTH-1:0] addr_in;
    logic [2*NUM_MASTERS-1:0]       burst_in;
    logic [NUM_MASTERS-1:0]         write_in;
    logic                           dev_wait;
    logic [NUM_MASTERS-1:0]         grant;
    logic [NUM_DEVICES-1:0]         device_en;
    logic [A_WIDTH-1:0]             bus_addr;
    logic [1:0]                     bus_burst;
    logic                           bus_write;
    logic                           bus_busy;
    logic                           timeout_err;
    logic                           decode_err;

    modport master (
        input  req, addr_in, burst_in, write_in, dev_wait,
        output grant, device_en, bus_addr, bus_burst, bus_write,
        output bus_busy, timeout_err, decode_err
    );

    modport slave (
        output req, addr_in, burst_in, write_in, dev_wait,
        input  grant, device_en, bus_addr, bus_burst, bus_write,
        input  bus_busy, timeout_err, decode_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin multi-master arbiter with device decode,
// burst beat tracking and wait-state timeout.
module bus_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int NUM_DEVICES  = 8,
    parameter int A_WIDTH      = 32,
    parameter int DEV_SEL_BITS = 3,
    parameter int TIMEOUT      = 255
) (
    input logic           clk,
    input logic           reset_L,
    bus_arbiter_if.master bus
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [A_WIDTH-1:0] SEL_MASK =
        {{DEV_SEL_BITS{1'b1}}, {(A_WIDTH-DEV_SEL_BITS){1'b0}}};

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          ptr, ptr_n, owner, owner_n, win;
    logic [3:0]             beats, beats_n;
    logic [WW-1:0]          wcnt, wcnt_n;
    logic [NUM_MASTERS-1:0] grant_q, grant_n;
    logic [NUM_DEVICES-1:0] dev_q, dev_n;
    logic [A_WIDTH-1:0]     addr_q, addr_n, sel_addr;
    logic [1:0]             burst_q, burst_n, sel_burst;
    logic                   write_q, write_n;
    logic                   terr_q, terr_n, derr_q, derr_n;
    logic                   found, done, abort, tmo;
    logic [DEV_SEL_BITS-1:0] dev_idx;
    int                     j;

    // First requester at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    assign sel_addr  = bus.addr_in[int'(win)*A_WIDTH +: A_WIDTH];
    assign sel_burst = bus.burst_in[2*int'(win) +: 2];
    assign dev_idx   = sel_addr[A_WIDTH-1 -: DEV_SEL_BITS];

    assign done  = !bus.dev_wait &&
                   (({1'b0, beats} + 5'd1) == (5'd1 << burst_q));
    assign abort = !bus.req[owner];
    assign tmo   = bus.dev_wait && ((int'(wcnt) + 1) >= TIMEOUT);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        beats_n = beats;
        wcnt_n  = wcnt;
        grant_n = grant_q;
        dev_n   = dev_q;
        addr_n  = addr_q;
        burst_n = burst_q;
        write_n = write_q;
        terr_n  = 1'b0;
        derr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_n = win;
                    addr_n  = sel_addr & ~SEL_MASK;
                    burst_n = sel_burst;
                    write_n = bus.write_in[win];
                    grant_n = NUM_MASTERS'(1) << win;
                    beats_n = '0;
                    wcnt_n  = '0;
                    if (int'(dev_idx) < NUM_DEVICES) begin
                        dev_n   = NUM_DEVICES'(1) << dev_idx;
                        state_n = GRANT;
                    end else begin
                        dev_n   = '0;
                        derr_n  = 1'b1;
                        state_n = RELEASE;
                    end
                end
            end
            GRANT: begin
                if (!bus.dev_wait) begin
                    beats_n = beats + 4'd1;
                    wcnt_n  = '0;
                end else if (wcnt != {WW{1'b1}}) begin
                    wcnt_n = wcnt + 1'b1;
                end
                if (done || abort || tmo) begin
                    terr_n  = !done && !abort;
                    grant_n = '0;
                    dev_n   = '0;
                    burst_n = '0;
                    write_n = 1'b0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                grant_n = '0;
                dev_n   = '0;
                burst_n = '0;
                write_n = 1'b0;
                ptr_n   = (int'(owner) == NUM_MASTERS-1) ? '0 : owner + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            beats   <= '0;
            wcnt    <= '0;
            grant_q <= '0;
            dev_q   <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            write_q <= 1'b0;
            terr_q  <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            beats   <= beats_n;
            wcnt    <= wcnt_n;
            grant_q <= grant_n;
            dev_q   <= dev_n;
            addr_q  <= addr_n;
            burst_q <= burst_n;
            write_q <= write_n;
            terr_q  <= terr_n;
            derr_q  <= derr_n;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.device_en   = dev_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_burst   = burst_q;
    assign bus.bus_write   = write_q;
    assign bus.bus_busy    = (state != IDLE);
    assign bus.timeout_err = terr_q;
    assign bus.decode_err  = derr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed test of bus_arbiter: 4 masters, 6 devices, timeout of 4.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset_L;
    int checks = 0;
    int errors = 0;

    bus_arbiter_if #(.NUM_MASTERS(4), .NUM_DEVICES(6), .A_WIDTH(32)) bus ();

    bus_arbiter #(
        .NUM_MASTERS(4), .NUM_DEVICES(6), .A_WIDTH(32),
        .DEV_SEL_BITS(3), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [31:0] a,
                         input logic [1:0] b, input logic w);
        bus.addr_in[i*32 +: 32] = a;
        bus.burst_in[i*2 +: 2]  = b;
        bus.write_in[i]         = w;
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        bus.req  = '0;
        bus.dev_wait = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L      = 1'b0;
        bus.req      = '0;
        bus.addr_in  = '0;
        bus.burst_in = '0;
        bus.write_in = '0;
        bus.dev_wait = 1'b0;

        // 1: reset with all requesting
        bus.req = 4'b1111;
        set_m(1, 32'h2000_0010, 2'd1, 1'b1);
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_dev", 32'(bus.device_en), 32'h0);
        check("rst_addr", bus.bus_addr, 32'h0);
        check("rst_burst", 32'(bus.bus_burst), 32'h0);
        check("rst_write", 32'(bus.bus_write), 32'h0);
        check("rst_busy", 32'(bus.bus_busy), 32'h0);
        check("rst_errs", 32'({bus.timeout_err, bus.decode_err}), 32'h0);
        reset_L = 1'b1;
        tick();
        check("rst_first_grant", 32'(bus.grant), 32'h1);
        do_reset();

        // 2: single beat, master 1
        set_m(1, 32'h2000_0010, 2'd0, 1'b1);
        bus.req = 4'b0010;
        tick();
        check("sb_grant", 32'(bus.grant), 32'h2);
        check("sb_dev", 32'(bus.device_en), 32'h02);
        check("sb_addr", bus.bus_addr, 32'h0000_0010);
        check("sb_write", 32'(bus.bus_write), 32'h1);
        check("sb_busy", 32'(bus.bus_busy), 32'h1);
        tick();
        check("sb_rel_grant", 32'(bus.grant), 32'h0);
        check("sb_rel_write", 32'(bus.bus_write), 32'h0);
        check("sb_rel_busy", 32'(bus.bus_busy), 32'h1);
        bus.req = '0;
        tick();
        check("sb_idle_busy", 32'(bus.bus_busy), 32'h0);

        // 3: 4-beat burst with 3 interleaved waits -> 7 grant cycles
        begin
            logic [6:0] pat;
            pat = 7'b0101010;
            set_m(0, 32'h4000_0100, 2'd2, 1'b0);
            bus.req = 4'b0001;
            tick();
            check("bw_dev", 32'(bus.device_en), 32'h04);
            check("bw_burst", 32'(bus.bus_burst), 32'h2);
            for (int k = 0; k < 7; k++) begin
                bus.dev_wait = pat[k];
                check($sformatf("bw_hold%0d", k), 32'(bus.grant), 32'h1);
                tick();
            end
            check("bw_released", 32'(bus.grant), 32'h0);
            check("bw_no_tmo", 32'(bus.timeout_err), 32'h0);
            bus.req = '0;
            bus.dev_wait = 1'b0;
            tick();
        end

        // 4: round robin from pointer 0, then master 3 joins
        do_reset();
        begin
            logic [3:0] exp_g [4];
            exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
            set_m(0, 32'h0000_0000, 2'd0, 1'b0);
            set_m(2, 32'h6000_0000, 2'd0, 1'b0);
            set_m(3, 32'hA000_0040, 2'd0, 1'b1);
            bus.req = 4'b0101;
            for (int g = 0; g < 4; g++) begin
                tick();
                check($sformatf("rr_grant%0d", g), 32'(bus.grant),
                      32'(exp_g[g]));
                if (g < 3) begin
                    tick();
                    tick();
                end
            end
            bus.req = 4'b1101;
            tick();
            tick();
            tick();
            check("rr_m3_grant", 32'(bus.grant), 32'h8);
            check("rr_m3_dev", 32'(bus.device_en), 32'h20);
            check("rr_m3_addr", bus.bus_addr, 32'h0000_0040);
            bus.req = '0;
            tick();
            tick();
        end

        // 5a: timeout with wait stuck high (pointer now 0)
        set_m(0, 32'h2000_0000, 2'd0, 1'b0);
        bus.req = 4'b0001;
        bus.dev_wait = 1'b1;
        tick();
        check("to_grant", 32'(bus.grant), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("to_wait%0d", k),
                  32'({bus.grant, bus.timeout_err}), 32'h2);
        end
        tick();
        check("to_pulse", 32'(bus.timeout_err), 32'h1);
        check("to_grant_off", 32'(bus.grant), 32'h0);
        bus.req = '0;
        bus.dev_wait = 1'b0;
        tick();
        check("to_pulse_end", 32'(bus.timeout_err), 32'h0);

        // 5b: owner drops req mid-burst (pointer now 1)
        set_m(1, 32'h2000_0000, 2'd3, 1'b0);
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        check("ab_mid", 32'(bus.grant), 32'h2);
        bus.req = '0;
        tick();
        check("ab_grant", 32'(bus.grant), 32'h0);
        check("ab_errs", 32'({bus.timeout_err, bus.decode_err}), 32'h0);
        tick();

        // 6a: unmapped device index 7 (pointer now 2)
        set_m(2, 32'hE000_0000, 2'd0, 1'b0);
        bus.req = 4'b0100;
        tick();
        check("de_grant", 32'(bus.grant), 32'h4);
        check("de_dev", 32'(bus.device_en), 32'h0);
        check("de_pulse", 32'(bus.decode_err), 32'h1);
        bus.req = '0;
        tick();
        check("de_grant_off", 32'(bus.grant), 32'h0);
        check("de_pulse_end", 32'(bus.decode_err), 32'h0);

        // 6b: reset mid-burst, pointer must return to 0
        set_m(1, 32'h2000_0000, 2'd3, 1'b1);
        bus.req = 4'b0010;
        tick();
        tick();
        check("rm_mid", 32'(bus.grant), 32'h2);
        reset_L = 1'b0;
        tick();
        check("rm_grant", 32'(bus.grant), 32'h0);
        check("rm_dev", 32'(bus.device_en), 32'h0);
        check("rm_addr", bus.bus_addr, 32'h0);
        check("rm_busy", 32'(bus.bus_busy), 32'h0);
        reset_L = 1'b1;
        bus.req = 4'b1010;
        tick();
        check("rm_ptr", 32'(bus.grant), 32'h2);
        bus.req = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
